// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters share one combinational ALU.
//
// Each port has a valid/ready request channel (operands + ALUControl code)
// and a valid/ready response channel (registered result + zero flag).
// At most one request is granted per cycle, round-robin on ties. The
// granted operands drive the ALU in the same cycle, and the ALU outputs
// are captured into that port's response register on the clock edge.
//
// Ports:
//   clk, reset                    clock (rising edge), synchronous active-high reset
//   reqN_valid/_ready             request handshake for port N (0 or 1)
//   reqN_a/_b/_op                 request operands and ALUControl code
//   rspN_valid/_ready             response handshake for port N
//   rspN_result/_zero             registered ALU result and zero flag
//   alu_a/_b/_ctrl                operands and code driven to the ALU
//   alu_result/_zero              ALU outputs sampled on a grant
module alu_share_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned OPW     = 4,
   parameter logic [OPW-1:0] NONE_OP = '1
) (
   input  logic             clk,
   input  logic             reset,
   // port 0
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_zero,
   // port 1
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_zero,
   // ALU side
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero
);

   logic             rsp0_valid_q, rsp0_valid_d;
   logic             rsp1_valid_q, rsp1_valid_d;
   logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
   logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
   logic             rsp0_zero_q, rsp0_zero_d;
   logic             rsp1_zero_q, rsp1_zero_d;
   logic             rr_last_q, rr_last_d;

   logic elig0, elig1;
   logic grant0, grant1;

   // A response slot is free if empty or being drained this very cycle.
   // Grants depend only on handshake state, never on alu_result.
   always_comb begin
      elig0  = req0_valid && (!rsp0_valid_q || rsp0_ready);
      elig1  = req1_valid && (!rsp1_valid_q || rsp1_ready);
      // Ties go to the port that did not win last; reset blocks all grants.
      grant0 = !reset && elig0 && (!elig1 || rr_last_q);
      grant1 = !reset && elig1 && (!elig0 || !rr_last_q);
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // ALU operand mux; idle code when nothing is granted.
   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = NONE_OP;
      if (grant0) begin
         alu_a    = req0_a;
         alu_b    = req0_b;
         alu_ctrl = req0_op;
      end else if (grant1) begin
         alu_a    = req1_a;
         alu_b    = req1_b;
         alu_ctrl = req1_op;
      end
   end

   always_comb begin
      rsp0_valid_d  = rsp0_valid_q;
      rsp0_result_d = rsp0_result_q;
      rsp0_zero_d   = rsp0_zero_q;
      rsp1_valid_d  = rsp1_valid_q;
      rsp1_result_d = rsp1_result_q;
      rsp1_zero_d   = rsp1_zero_q;
      rr_last_d     = rr_last_q;

      // A new grant overrides a same-cycle drain so valid stays high.
      if (grant0) begin
         rsp0_valid_d  = 1'b1;
         rsp0_result_d = alu_result;
         rsp0_zero_d   = alu_zero;
         rr_last_d     = 1'b0;
      end else if (rsp0_ready) begin
         rsp0_valid_d  = 1'b0;
      end

      if (grant1) begin
         rsp1_valid_d  = 1'b1;
         rsp1_result_d = alu_result;
         rsp1_zero_d   = alu_zero;
         rr_last_d     = 1'b1;
      end else if (rsp1_ready) begin
         rsp1_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp0_valid_q  <= 1'b0;
         rsp0_result_q <= '0;
         rsp0_zero_q   <= 1'b0;
         rsp1_valid_q  <= 1'b0;
         rsp1_result_q <= '0;
         rsp1_zero_q   <= 1'b0;
         rr_last_q     <= 1'b1;  // port 0 wins the first tie
      end else begin
         rsp0_valid_q  <= rsp0_valid_d;
         rsp0_result_q <= rsp0_result_d;
         rsp0_zero_q   <= rsp0_zero_d;
         rsp1_valid_q  <= rsp1_valid_d;
         rsp1_result_q <= rsp1_result_d;
         rsp1_zero_q   <= rsp1_zero_d;
         rr_last_q     <= rr_last_d;
      end
   end

   assign rsp0_valid  = rsp0_valid_q;
   assign rsp0_result = rsp0_result_q;
   assign rsp0_zero   = rsp0_zero_q;
   assign rsp1_valid  = rsp1_valid_q;
   assign rsp1_result = rsp1_result_q;
   assign rsp1_zero   = rsp1_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached.
module tb_alu_share_arbiter;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned OPW   = 4;
   localparam logic [OPW-1:0] ALU_ADD  = 4'd0;
   localparam logic [OPW-1:0] ALU_SUB  = 4'd1;
   localparam logic [OPW-1:0] ALU_XOR  = 4'd4;
   localparam logic [OPW-1:0] ALU_SLT  = 4'd5;
   localparam logic [OPW-1:0] ALU_NONE = 4'hF;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
   logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
   logic [OPW-1:0]   req0_op, req1_op;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic [OPW-1:0]   alu_ctrl;
   logic             alu_zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Reference ALU standing in for the real instance.
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         ALU_ADD: alu_result = alu_a + alu_b;
         ALU_SUB: alu_result = alu_a - alu_b;
         ALU_XOR: alu_result = alu_a ^ alu_b;
         ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   alu_share_arbiter #(
      .WIDTH  (WIDTH),
      .OPW    (OPW),
      .NONE_OP(ALU_NONE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_result(rsp0_result),
      .rsp0_zero  (rsp0_zero),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_result(rsp1_result),
      .rsp1_zero  (rsp1_zero),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .alu_zero   (alu_zero)
   );

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                      input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = ALU_ADD; rsp0_ready = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = ALU_ADD; rsp1_ready = 1'b0;

      // Reset for two cycles.
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_rsp0_result", rsp0_result, 0);
      chk("rst_rsp1_result", rsp1_result, 0);
      chk("rst_alu_ctrl", alu_ctrl, ALU_NONE);
      chk("rst_alu_a", alu_a, 0);

      // Single request on port 0: 5 + 7.
      req0_valid = 1'b1; req0_a = 5; req0_b = 7; req0_op = ALU_ADD; rsp0_ready = 1'b1;
      #1;
      chk("add_req0_ready", req0_ready, 1);
      chk("add_req1_ready", req1_ready, 0);
      chk("add_alu_a", alu_a, 5);
      chk("add_alu_ctrl", alu_ctrl, ALU_ADD);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("add_rsp0_valid", rsp0_valid, 1);
      chk("add_rsp0_result", rsp0_result, 12);
      chk("add_rsp0_zero", rsp0_zero, 0);
      chk("add_idle_ctrl", alu_ctrl, ALU_NONE);
      tick();
      #1;
      chk("add_rsp0_drained", rsp0_valid, 0);

      // Contention: both valid every cycle, grants alternate 0,1,0,1.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req0_valid = 1'b1; req0_a = 9; req0_b = 9; req0_op = ALU_SUB;
      req1_valid = 1'b1; req1_a = 3; req1_b = 1; req1_op = ALU_XOR;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
         chk("rr_req1_ready", req1_ready, (i % 2 == 1) ? 1 : 0);
         tick();
         if (i % 2 == 0) begin
            chk("rr_rsp0_valid", rsp0_valid, 1);
            chk("rr_rsp0_result", rsp0_result, 0);
            chk("rr_rsp0_zero", rsp0_zero, 1);
         end else begin
            chk("rr_rsp1_valid", rsp1_valid, 1);
            chk("rr_rsp1_result", rsp1_result, 2);
            chk("rr_rsp1_zero", rsp1_zero, 0);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      // Back-pressure on port 0; port 1 keeps flowing every cycle.
      req0_valid = 1'b1; req0_a = 10; req0_b = 20; req0_op = ALU_ADD;
      req1_valid = 1'b1; req1_a = 1;  req1_b = 0;  req1_op = ALU_ADD;
      rsp0_ready = 1'b0; rsp1_ready = 1'b1;
      #1;
      chk("bp_first_req0_ready", req0_ready, 1);
      chk("bp_first_req1_ready", req1_ready, 0);
      tick();
      req0_a = 8; req0_b = 5; req0_op = ALU_SUB;
      #1;
      chk("bp_rsp0_valid", rsp0_valid, 1);
      chk("bp_rsp0_result", rsp0_result, 30);
      for (int k = 1; k <= 3; k++) begin
         req1_b = k;
         #1;
         chk("bp_req0_blocked", req0_ready, 0);
         chk("bp_req1_ready", req1_ready, 1);
         tick();
         chk("bp_rsp1_result", rsp1_result, 1 + k);
         chk("bp_rsp0_held", rsp0_result, 30);
         chk("bp_rsp0_still_valid", rsp0_valid, 1);
      end
      // Draining port 0 frees its slot in the same cycle.
      rsp0_ready = 1'b1;
      #1;
      chk("bp_release_req0_ready", req0_ready, 1);
      chk("bp_release_req1_ready", req1_ready, 0);
      tick();
      chk("bp_release_rsp0_valid", rsp0_valid, 1);
      chk("bp_release_rsp0_result", rsp0_result, 3);

      // Back-to-back on port 0: ADD 1+1 then SLT -1<2.
      req1_valid = 1'b0;
      req0_a = 1; req0_b = 1; req0_op = ALU_ADD;
      #1;
      chk("b2b_req0_ready_a", req0_ready, 1);
      tick();
      req0_a = 32'hFFFF_FFFF; req0_b = 2; req0_op = ALU_SLT;
      #1;
      chk("b2b_rsp0_valid_a", rsp0_valid, 1);
      chk("b2b_rsp0_result_a", rsp0_result, 2);
      chk("b2b_req0_ready_b", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("b2b_rsp0_valid_b", rsp0_valid, 1);
      chk("b2b_rsp0_result_b", rsp0_result, 1);
      chk("b2b_rsp0_zero_b", rsp0_zero, 0);
      tick();
      chk("b2b_rsp0_drained", rsp0_valid, 0);

      // Reset while port 1 holds a response and still requests.
      req1_valid = 1'b1; req1_a = 4; req1_b = 4; req1_op = ALU_ADD; rsp1_ready = 1'b0;
      #1;
      chk("mid_req1_ready", req1_ready, 1);
      tick();
      chk("mid_rsp1_valid", rsp1_valid, 1);
      chk("mid_rsp1_result", rsp1_result, 8);
      reset = 1'b1;
      req0_valid = 1'b1; req0_a = 2; req0_b = 2; req0_op = ALU_ADD;
      #1;
      chk("mid_rst_req0_ready", req0_ready, 0);
      chk("mid_rst_req1_ready", req1_ready, 0);
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rst_rsp1_valid", rsp1_valid, 0);
      chk("mid_rst_rsp1_result", rsp1_result, 0);
      chk("post_rst_req0_ready", req0_ready, 1);
      chk("post_rst_req1_ready", req1_ready, 0);
      tick();
      chk("post_rst_rsp0_valid", rsp0_valid, 1);
      chk("post_rst_rsp0_result", rsp0_result, 4);
      chk("post_rst_rsp1_valid", rsp1_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters, e.g. the integer pipeline (port 0) and an address/loop helper (port 1).
- Each port has a valid/ready request channel and a valid/ready response channel.
- One operation is granted per cycle, round-robin. The result and zero flag are registered into a per-port response buffer.
- The block sits between the requesters and the ALU instance. It drives the ALU operands and ALUControl code and samples Result/Zero.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- OPW, 4, ALUControl code width.
- NONE_OP, ALU_NONE encoding from the shared defines, code driven to the ALU when no grant.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  port 0 request valid
- req0_ready  output  1  port 0 request accepted this cycle
- req0_a  input  WIDTH  port 0 operand A
- req0_b  input  WIDTH  port 0 operand B
- req0_op  input  OPW  port 0 ALUControl code
- rsp0_valid  output  1  port 0 response valid
- rsp0_ready  input  1  port 0 consumes response
- rsp0_result  output  WIDTH  port 0 registered result
- rsp0_zero  output  1  port 0 registered zero flag
- req1_*, rsp1_*  same as port 0, for port 1
- alu_a  output  WIDTH  to ALU A
- alu_b  output  WIDTH  to ALU B
- alu_ctrl  output  OPW  to ALU ALUControl
- alu_result  input  WIDTH  from ALU Result
- alu_zero  input  1  from ALU Zero

Behaviour:
- Reset (synchronous, active-high, priority over all else):
  - rsp0_valid/rsp1_valid=0; rsp*_result=0; rsp*_zero=0.
  - rr_last=1, so port 0 wins the first tie.
  - Reset mid-operation discards any pending response.
- Eligibility:
  - port i is eligible when reqi_valid=1 AND its response slot is free.
  - The slot is free when rspi_valid=0 OR rspi_ready=1 in the same cycle (back-to-back accepted).
- Grant (combinational, same cycle):
  - one eligible port → grant it.
  - both eligible → grant the port != rr_last.
  - none eligible → no grant.
  - reqi_ready = grant_i. At most one ready high per cycle.
- ALU drive:
  - on grant: alu_a/alu_b/alu_ctrl = granted port's a/b/op.
  - otherwise: alu_a=0, alu_b=0, alu_ctrl=NONE_OP.
- Capture:
  - on a grant at edge T, store alu_result/alu_zero into the granted port's response register; rspi_valid=1 from T+1.
  - Latency: request accepted in cycle N → response visible in cycle N+1.
  - rr_last updates to the granted index only on a grant.
- Response handshake:
  - rspi_valid && rspi_ready with no new grant to i → rspi_valid clears next cycle.
  - Same-cycle accept and new grant → rspi_valid stays 1 with the new data.
  - Response data is held stable while valid && !ready.
- Back-pressure: rspi_valid=1 and rspi_ready=0 → reqi_ready=0. The other port is unaffected; it may take every cycle.
- Requester rules: requesters must hold a/b/op stable while valid && !ready. The arbiter does not latch request data before grant.
- Opcodes: passed to the ALU unmodified; no decode, no width conversion.
- Throughput: one op per cycle aggregate. Fairness: a continuously valid, unblocked port waits at most 1 cycle.
- No combinational path from alu_result to any ready signal.

Test Plan:
- Reset held 2 cycles then released → rsp0/1_valid=0, results 0, alu_ctrl=NONE_OP, alu_a=0.
- Only port 0 valid, a=5, b=7, op=ALU_ADD, rsp0_ready=1 → req0_ready=1 in cycle N. Cycle N+1: rsp0_valid=1, result=12, zero=0.
- Both ports valid every cycle, both rsp_ready=1:
  - port0: SUB 9-9; port1: XOR 3^1.
  - Grants alternate 0,1,0,1.
  - port0 result=0, zero=1; port1 result=2.
- Port 0 rsp0_ready=0 after first response, port 1 continuously valid → req0_ready=0 while blocked; port1 granted every cycle; rsp0_result held constant.
- Back-to-back on port 0, rsp0_ready=1, ops ADD 1+1 then SLT -1<2 → rsp0_valid stays 1 across both. Results 2 then 1 on consecutive cycles.
- Reset asserted while rsp1_valid=1 and req1_valid=1 → next cycle rsp1_valid=0, no grant. After release, port 0 wins the first tie.
